// File: rtl/slice_carry_merge.sv
// Ripples inter-slice carries across per-slice adder outputs (LSB slice first) and
// assembles the full-width sum, carry-out and overflow flag behind a valid/ready port.
module slice_carry_merge #(
    parameter int WIDTH = 128,
    parameter int SLICE = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c_in,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [SLICE:0]   s_sum,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_sum,
    output logic             m_cout,
    output logic             m_ovf
);

    localparam int NSLICE = (WIDTH + SLICE - 1) / SLICE;
    localparam int AW     = NSLICE * SLICE;
    localparam int LOW_W  = (NSLICE - 1) * SLICE;
    localparam int IDX_W  = $clog2(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic {ACC, OUT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [LOW_W-1:0] acc;

    logic             accept;
    logic             last;
    logic             cin_eff;
    logic [SLICE:0]   t;
    logic             nc;
    logic [AW-1:0]    assembled;

    assign s_ready   = (state == ACC);
    assign m_valid   = (state == OUT);
    assign accept    = s_valid && s_ready;
    assign last      = (idx == LAST_IDX);
    assign cin_eff   = (idx == '0) ? c_in : carry;
    assign t         = {1'b0, s_sum[SLICE-1:0]} + (SLICE+1)'(cin_eff);
    // An upstream slice sum never has both its carry bit and a low-field overflow set.
    assign nc        = s_sum[SLICE] | t[SLICE];
    // The top slice goes straight into the result, so acc only holds the lower slices.
    assign assembled = {t[SLICE-1:0], acc};

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACC;
        else     state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block purely combinational; any
    // path that left state_nxt unassigned would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ACC: if (accept && last) state_nxt = OUT;
            OUT: if (m_ready)        state_nxt = ACC;
            default:                 state_nxt = ACC;
        endcase
    end

    // NOTE: acc is a plain register bank rather than a RAM, so it is cleared on reset
    // and a reset mid-operation leaves no stale partial sum behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            acc    <= '0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (accept) begin
            carry <= nc;
            if (last) begin
                idx    <= '0;
                m_sum  <= assembled[WIDTH-1:0];
                m_cout <= assembled[WIDTH];
                m_ovf  <= (|assembled[AW-1:WIDTH+1]) | nc;
            end else begin
                idx <= idx + 1'b1;
                acc[int'(idx)*SLICE +: SLICE] <= t[SLICE-1:0];
            end
        end
    end

endmodule

// File: tb/tb_slice_carry_merge.sv
// Directed and random bench for slice_carry_merge: a value-level reference model
// (weighted sum of slice values) checks every output cycle, plus literal expectations.
module tb_slice_carry_merge;

    localparam int WIDTH  = 128;
    localparam int SLICE  = 6;
    localparam int NSLICE = 22;

    logic             clk     = 1'b0;
    logic             rst;
    logic             c_in    = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [SLICE:0]   s_sum   = '0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [WIDTH-1:0] m_sum;
    logic             m_cout;
    logic             m_ovf;

    typedef struct {
        logic [127:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t       exp_q[$];
    int         stamps[$];
    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;
    bit         stall_mode = 1'b0;
    logic [6:0] slices [NSLICE];
    logic       exp_valid  = 1'b0;
    logic       prev_valid = 1'b0;
    int         beat = 0;

    slice_carry_merge #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk     (clk),
        .rst     (rst),
        .c_in    (c_in),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sum   (s_sum),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_sum   (m_sum),
        .m_cout  (m_cout),
        .m_ovf   (m_ovf)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result is the carry-in plus every slice value weighted by 64^i.
    function automatic res_t model(input logic cin);
        logic [139:0] v;
        res_t         r;
        v = {139'b0, cin};
        for (int i = 0; i < NSLICE; i++)
            v = v + ({133'b0, slices[i]} << (SLICE * i));
        r.sum  = v[127:0];
        r.cout = v[128];
        r.ovf  = |v[139:129];
        return r;
    endfunction

    // Handshake-level model: a result becomes valid after every 22nd accepted beat.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_valid <= 1'b0;
            beat      <= 0;
            exp_q.delete();
        end else if (exp_valid) begin
            if (m_ready) begin
                exp_valid <= 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end else if (s_valid) begin
            if (beat == NSLICE - 1) begin
                beat      <= 0;
                exp_valid <= 1'b1;
            end else begin
                beat <= beat + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("s_ready", {127'b0, s_ready}, {127'b0, !exp_valid});
        check("m_valid", {127'b0, m_valid}, {127'b0, exp_valid});
        if (exp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL result_queue: got result expected none pending");
            end else begin
                check("m_sum",  m_sum,             exp_q[0].sum);
                check("m_cout", {127'b0, m_cout},  {127'b0, exp_q[0].cout});
                check("m_ovf",  {127'b0, m_ovf},   {127'b0, exp_q[0].ovf});
            end
        end
        if (m_valid && !prev_valid) stamps.push_back(cyc);
        prev_valid = m_valid;
    end

    always @(posedge clk) begin
        #1;
        m_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 2000) begin
                $display("FAIL accept_timeout: got s_ready=0 expected 1 within 2000 cycles");
                $fatal(1, "stuck waiting for s_ready");
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 || exp_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 2000) begin
                $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
                $fatal(1, "results never drained");
            end
        end
    endtask

    task automatic build(input logic [127:0] a, input logic [127:0] b);
        logic [131:0] aa;
        logic [131:0] bb;
        aa = {4'b0, a};
        bb = {4'b0, b};
        for (int i = 0; i < NSLICE; i++)
            slices[i] = {1'b0, aa[SLICE*i +: SLICE]} + {1'b0, bb[SLICE*i +: SLICE]};
    endtask

    task automatic fill_test1();
        slices[0] = 7'd64;
        for (int i = 1; i < NSLICE - 1; i++) slices[i] = 7'd63;
        slices[NSLICE-1] = 7'd3;
    endtask

    task automatic send_op(input logic cin_v, input int gap_max, input int abort_at);
        if (abort_at < 0) exp_q.push_back(model(cin_v));
        for (int i = 0; i < NSLICE; i++) begin
            int gap;
            gap = (gap_max > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, gap_max)) : 0;
            repeat (gap) begin
                s_valid = 1'b0;
                s_sum   = 7'($urandom);
                c_in    = 1'($urandom);
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_sum   = slices[i];
            c_in    = (i == 0) ? cin_v : 1'($urandom);
            wait_accept();
            s_valid = 1'b0;
            s_sum   = 7'($urandom);
            if (i == abort_at) begin
                rst = 1'b1;
                #2;
                check("rst_m_valid", {127'b0, m_valid}, 128'd0);
                check("rst_s_ready", {127'b0, s_ready}, 128'd1);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic check_literal(input string tag, input logic [127:0] sum,
                                 input logic cout, input logic ovf);
        @(negedge clk);
        check({tag, "_latency"}, {127'b0, m_valid}, 128'd1);
        check({tag, "_sum"},     m_sum,             sum);
        check({tag, "_cout"},    {127'b0, m_cout},  {127'b0, cout});
        check({tag, "_ovf"},     {127'b0, m_ovf},   {127'b0, ovf});
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_m_valid", {127'b0, m_valid}, 128'd0);
        check("reset_s_ready", {127'b0, s_ready}, 128'd1);
        check("reset_m_sum",   m_sum,             128'd0);
        check("reset_m_cout",  {127'b0, m_cout},  128'd0);
        check("reset_m_ovf",   {127'b0, m_ovf},   128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All-ones plus one: carry ripples through every slice.
        fill_test1();
        send_op(1'b0, 0, -1);
        check_literal("t1", 128'd0, 1'b1, 1'b0);
        wait_drain();

        // Zero operands, carry-in only.
        for (int i = 0; i < NSLICE; i++) slices[i] = 7'd0;
        send_op(1'b1, 2, -1);
        check_literal("t2", 128'd1, 1'b0, 1'b0);
        wait_drain();

        // Top-slice bits landing above the result width.
        for (int i = 0; i < NSLICE; i++) slices[i] = 7'd0;
        slices[NSLICE-1] = 7'd16;
        send_op(1'b0, 0, -1);
        check_literal("t4_ovf", 128'd0, 1'b0, 1'b1);
        wait_drain();
        slices[NSLICE-1] = 7'd4;
        send_op(1'b0, 0, -1);
        check_literal("t4_cout", 128'd0, 1'b1, 1'b0);
        wait_drain();

        // Reset in the middle of an operation, then a clean carry-heavy op.
        build({$urandom, $urandom, $urandom, $urandom}, {4{32'hffff_ffff}});
        send_op(1'b1, 0, 10);
        fill_test1();
        send_op(1'b0, 0, -1);
        check_literal("t5", 128'd0, 1'b1, 1'b0);
        wait_drain();

        // Back-to-back operations with the consumer always ready.
        stall_mode = 1'b0;
        stamps.delete();
        for (int k = 0; k < 4; k++) begin
            build({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            send_op(1'($urandom), 0, -1);
        end
        wait_drain();
        check("t6_results", 128'(stamps.size()), 128'd4);
        for (int k = 1; k < 4 && k < stamps.size(); k++)
            check("t6_period", 128'(stamps[k] - stamps[k-1]), 128'd23);

        // Random operands with input gaps and output stalls.
        stall_mode = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            build({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            send_op(1'($urandom), 3, -1);
        end
        wait_drain();
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
